// File: rtl/mac_multiplier_pipe.sv
// Two-stage sign/exponent/mantissa multiplier; radix-4 Booth partial products when MAC_MULT_BOOTH_EN is defined.
// Latency 2 cycles; valid/ready stall with i_ready combinational from o_ready (no skid).
module mac_multiplier_pipe #(
  parameter int EXP_W  = 4,
  parameter int MANT_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_valid,
  output logic              i_ready,
  input  logic              a_sign,
  input  logic              b_sign,
  input  logic [EXP_W-1:0]  a_exp,
  input  logic [EXP_W-1:0]  b_exp,
  input  logic [MANT_W-1:0] a_mant,
  input  logic [MANT_W-1:0] b_mant,
  output logic              o_valid,
  input  logic              o_ready,
  output logic              o_sign,
  output logic [EXP_W:0]    o_exp,
  output logic [2*MANT_W+1:0] o_mant,
  output logic              o_zero
);
  localparam int PW  = 2*MANT_W+2;
  localparam int NPP = MANT_W/2+1;

  logic s1_v, s2_v, s1_ld, s2_ld, in_xfer, in_zero;
  logic s1_sign, s1_zero;
  logic [EXP_W:0] s1_exp;
  logic [PW-1:0] prod;

  assign s2_ld   = !s2_v || o_ready;
  assign s1_ld   = !s1_v || s2_ld;
  assign i_ready = s1_ld;
  assign o_valid = s2_v;
  assign in_xfer = i_valid && s1_ld;
  assign in_zero = (a_mant == '0) || (b_mant == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_v    <= 1'b0;
      s2_v    <= 1'b0;
      s1_sign <= 1'b0;
      s1_zero <= 1'b0;
      s1_exp  <= '0;
    end else begin
      if (s1_ld) s1_v <= i_valid;
      if (s2_ld) s2_v <= s1_v;
      if (in_xfer) begin
        s1_sign <= a_sign ^ b_sign;
        s1_zero <= in_zero;
        s1_exp  <= in_zero ? '0 : ({1'b0, a_exp} + {1'b0, b_exp});
      end
    end
  end

`ifdef MAC_MULT_BOOTH_EN
  // Zero pad above b_mant makes the top digit non-negative, so unsigned b recodes exactly.
  logic [MANT_W+2:0] bx;
  logic [PW-1:0] pp_next [NPP];
  logic [PW-1:0] s1_pp [NPP];

  assign bx = {2'b00, b_mant, 1'b0};

  for (genvar g = 0; g < NPP; g++) begin : g_pp
    logic [2:0]    trip;
    logic [PW-1:0] mag;
    logic [PW-1:0] sgn;
    assign trip = bx[2*g+2 -: 3];
    always_comb begin
      case (trip)
        3'b001, 3'b010, 3'b101, 3'b110: mag = PW'(a_mant);
        3'b011, 3'b100:                 mag = PW'(a_mant) << 1;
        default:                        mag = '0;
      endcase
      sgn = trip[2] ? -mag : mag;
    end
    assign pp_next[g] = sgn << (2*g);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NPP; i++) s1_pp[i] <= '0;
    end else if (in_xfer) begin
      for (int i = 0; i < NPP; i++) s1_pp[i] <= pp_next[i];
    end
  end

  // Sum wraps modulo 2^PW; the true product always fits, so the result is exact.
  always_comb begin
    prod = '0;
    for (int i = 0; i < NPP; i++) prod = prod + s1_pp[i];
  end
`else
  logic [MANT_W-1:0] s1_a, s1_b;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_a <= '0;
      s1_b <= '0;
    end else if (in_xfer) begin
      s1_a <= a_mant;
      s1_b <= b_mant;
    end
  end

  assign prod = PW'(s1_a) * PW'(s1_b);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_sign <= 1'b0;
      o_exp  <= '0;
      o_mant <= '0;
      o_zero <= 1'b0;
    end else if (s2_ld && s1_v) begin
      o_sign <= s1_sign;
      o_exp  <= s1_exp;
      o_mant <= s1_zero ? '0 : prod;
      o_zero <= s1_zero;
    end
  end
endmodule

// File: tb/tb_mac_multiplier_pipe.sv
// Directed and random checks of mac_multiplier_pipe at MANT_W=8, plus MANT_W=4 and 12 corner products.
module tb_mac_multiplier_pipe;
  typedef struct packed {
    logic sign; logic [4:0] exp; logic [17:0] mant; logic zero;
  } res_t;
  typedef struct packed {
    logic as; logic [3:0] ae; logic [7:0] am;
    logic bs; logic [3:0] be; logic [7:0] bm;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic i_valid = 1'b0, i_ready, o_valid, o_ready = 1'b1;
  logic a_sign = 1'b0, b_sign = 1'b0, o_sign, o_zero;
  logic [3:0] a_exp = '0, b_exp = '0;
  logic [7:0] a_mant = '0, b_mant = '0;
  logic [4:0] o_exp;
  logic [17:0] o_mant;

  logic w4_i_valid = 1'b0, w4_i_ready, w4_o_valid, w4_o_sign, w4_o_zero;
  logic [3:0] w4_a_mant = '0, w4_b_mant = '0;
  logic [4:0] w4_o_exp;
  logic [9:0] w4_o_mant;

  logic w12_i_valid = 1'b0, w12_i_ready, w12_o_valid, w12_o_sign, w12_o_zero;
  logic [11:0] w12_a_mant = '0, w12_b_mant = '0;
  logic [4:0] w12_o_exp;
  logic [25:0] w12_o_mant;

  int tests = 0;
  int fails = 0;

  mac_multiplier_pipe #(.EXP_W(4), .MANT_W(8)) dut (
    .clk(clk), .rst(rst), .i_valid(i_valid), .i_ready(i_ready),
    .a_sign(a_sign), .b_sign(b_sign), .a_exp(a_exp), .b_exp(b_exp),
    .a_mant(a_mant), .b_mant(b_mant), .o_valid(o_valid), .o_ready(o_ready),
    .o_sign(o_sign), .o_exp(o_exp), .o_mant(o_mant), .o_zero(o_zero)
  );

  mac_multiplier_pipe #(.EXP_W(4), .MANT_W(4)) dut_w4 (
    .clk(clk), .rst(rst), .i_valid(w4_i_valid), .i_ready(w4_i_ready),
    .a_sign(1'b0), .b_sign(1'b0), .a_exp(4'd0), .b_exp(4'd0),
    .a_mant(w4_a_mant), .b_mant(w4_b_mant), .o_valid(w4_o_valid), .o_ready(1'b1),
    .o_sign(w4_o_sign), .o_exp(w4_o_exp), .o_mant(w4_o_mant), .o_zero(w4_o_zero)
  );

  mac_multiplier_pipe #(.EXP_W(4), .MANT_W(12)) dut_w12 (
    .clk(clk), .rst(rst), .i_valid(w12_i_valid), .i_ready(w12_i_ready),
    .a_sign(1'b0), .b_sign(1'b0), .a_exp(4'd0), .b_exp(4'd0),
    .a_mant(w12_a_mant), .b_mant(w12_b_mant), .o_valid(w12_o_valid), .o_ready(1'b1),
    .o_sign(w12_o_sign), .o_exp(w12_o_exp), .o_mant(w12_o_mant), .o_zero(w12_o_zero)
  );

  function automatic res_t got();
    return '{sign: o_sign, exp: o_exp, mant: o_mant, zero: o_zero};
  endfunction

  function automatic res_t model(input vec_t v);
    res_t r;
    r.zero = (v.am == 8'd0) || (v.bm == 8'd0);
    r.sign = v.as ^ v.bs;
    r.exp  = r.zero ? 5'd0 : ({1'b0, v.ae} + {1'b0, v.be});
    r.mant = 18'(v.am) * 18'(v.bm);
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply(input vec_t v);
    i_valid = 1'b1;
    a_sign = v.as; a_exp = v.ae; a_mant = v.am;
    b_sign = v.bs; b_exp = v.be; b_mant = v.bm;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    apply('{as: 1'b1, ae: 4'h3, am: 8'h55, bs: 1'b0, be: 4'h2, bm: 8'h33});
    repeat (3) tick();
    tests++; if (o_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b want 0", o_valid); end
    tests++; if (o_mant !== 18'd0) begin fails++; $display("FAIL reset_mant: got %h want 0", o_mant); end
    tests++; if (o_exp !== 5'd0) begin fails++; $display("FAIL reset_exp: got %h want 0", o_exp); end
    tests++; if ({o_sign, o_zero} !== 2'b00) begin fails++; $display("FAIL reset_flags: got %b want 00", {o_sign, o_zero}); end
    rst = 1'b0;
    i_valid = 1'b0;
    #1;
    tests++; if (i_ready !== 1'b1) begin fails++; $display("FAIL reset_iready: got %b want 1", i_ready); end
    tick();
    tests++; if (o_valid !== 1'b0) begin fails++; $display("FAIL reset_idle_valid: got %b want 0", o_valid); end
  endtask

  task automatic test_single();
    res_t want;
    want = '{sign: 1'b1, exp: 5'd30, mant: 18'h0FE01, zero: 1'b0};
    o_ready = 1'b1;
    apply('{as: 1'b0, ae: 4'hF, am: 8'hFF, bs: 1'b1, be: 4'hF, bm: 8'hFF});
    tick();
    i_valid = 1'b0;
    tests++; if (o_valid !== 1'b0) begin fails++; $display("FAIL single_early: o_valid got %b want 0", o_valid); end
    tick();
    tests++; if (o_valid !== 1'b1) begin fails++; $display("FAIL single_valid: got %b want 1", o_valid); end
    tests++; if (got() !== want) begin fails++; $display("FAIL single_data: got %h want %h", got(), want); end
    tick();
    tests++; if (o_valid !== 1'b0) begin fails++; $display("FAIL single_drain: o_valid got %b want 0", o_valid); end
  endtask

  task automatic test_zero();
    res_t want;
    want = '{sign: 1'b0, exp: 5'd0, mant: 18'd0, zero: 1'b1};
    apply('{as: 1'b1, ae: 4'd3, am: 8'h00, bs: 1'b1, be: 4'd7, bm: 8'h5A});
    tick();
    i_valid = 1'b0;
    tick();
    tests++; if (o_valid !== 1'b1) begin fails++; $display("FAIL zero_valid: got %b want 1", o_valid); end
    tests++; if (got() !== want) begin fails++; $display("FAIL zero_data: got %h want %h", got(), want); end
    tick();
  endtask

  task automatic test_backpressure();
    vec_t v[4];
    res_t e[4];
    res_t held;
    int k, n;
    v[0] = '{as: 1'b0, ae: 4'h1, am: 8'h03, bs: 1'b0, be: 4'h2, bm: 8'h05};
    v[1] = '{as: 1'b1, ae: 4'h4, am: 8'h10, bs: 1'b0, be: 4'h5, bm: 8'h0A};
    v[2] = '{as: 1'b0, ae: 4'hF, am: 8'h80, bs: 1'b1, be: 4'h0, bm: 8'h80};
    v[3] = '{as: 1'b1, ae: 4'h7, am: 8'hFF, bs: 1'b1, be: 4'h8, bm: 8'h01};
    e[0] = '{sign: 1'b0, exp: 5'd3,  mant: 18'h0000F, zero: 1'b0};
    e[1] = '{sign: 1'b1, exp: 5'd9,  mant: 18'h000A0, zero: 1'b0};
    e[2] = '{sign: 1'b1, exp: 5'd15, mant: 18'h04000, zero: 1'b0};
    e[3] = '{sign: 1'b0, exp: 5'd15, mant: 18'h000FF, zero: 1'b0};
    o_ready = 1'b0;
    k = 0;
    for (int c = 0; c < 6 && k < 4; c++) begin
      apply(v[k]);
      #1;
      if (i_ready) k++;
      tick();
    end
    tests++; if (k !== 2) begin fails++; $display("FAIL bp_accepted: got %0d want 2", k); end
    #1;
    tests++; if (i_ready !== 1'b0) begin fails++; $display("FAIL bp_iready: got %b want 0", i_ready); end
    held = got();
    repeat (3) tick();
    tests++; if (o_valid !== 1'b1 || got() !== e[0]) begin
      fails++; $display("FAIL bp_hold: valid %b data %h want 1 %h (first seen %h)", o_valid, got(), e[0], held);
    end
    o_ready = 1'b1;
    n = 0;
    for (int c = 0; c < 12; c++) begin
      if (k < 4) apply(v[k]); else i_valid = 1'b0;
      #1;
      if (o_valid) begin
        tests++;
        if (n >= 4) begin fails++; $display("FAIL bp_extra: got %h want none", got()); end
        else if (got() !== e[n]) begin fails++; $display("FAIL bp_order%0d: got %h want %h", n, got(), e[n]); end
        n++;
      end
      if (i_valid && i_ready) k++;
      tick();
    end
    tests++; if (n !== 4) begin fails++; $display("FAIL bp_count: got %0d want 4", n); end
  endtask

  task automatic test_back_to_back();
    res_t q[$];
    res_t exp_r;
    vec_t v;
    int sent, rcv, stalls, first_c;
    sent = 0; rcv = 0; stalls = 0; first_c = -1;
    o_ready = 1'b1;
    for (int c = 0; c < 1100 && rcv < 1000; c++) begin
      if (sent < 1000) begin
        v = vec_t'({$urandom, $urandom});
        if ($urandom_range(0, 15) == 0) v.am = 8'd0;
        if ($urandom_range(0, 15) == 0) v.bm = 8'd0;
        apply(v);
      end else i_valid = 1'b0;
      #1;
      if (o_valid) begin
        if (first_c < 0) first_c = c;
        tests++;
        if (q.size() == 0) begin fails++; $display("FAIL stream_extra: got %h want none", got()); end
        else begin
          exp_r = q.pop_front();
          if (got() !== exp_r) begin fails++; $display("FAIL stream_data%0d: got %h want %h", rcv, got(), exp_r); end
        end
        rcv++;
      end
      if (i_valid && !i_ready) stalls++;
      if (i_valid && i_ready) begin q.push_back(model(v)); sent++; end
      tick();
    end
    i_valid = 1'b0;
    tests++; if (rcv !== 1000) begin fails++; $display("FAIL stream_count: got %0d want 1000", rcv); end
    tests++; if (stalls !== 0) begin fails++; $display("FAIL stream_stalls: got %0d want 0", stalls); end
    tests++; if (first_c !== 2) begin fails++; $display("FAIL stream_latency: got %0d want 2", first_c); end
  endtask

  task automatic test_reset_midop();
    o_ready = 1'b1;
    apply('{as: 1'b0, ae: 4'h2, am: 8'h12, bs: 1'b0, be: 4'h2, bm: 8'h34});
    tick();
    i_valid = 1'b0;
    rst = 1'b1;
    #1;
    tests++; if (o_valid !== 1'b0) begin fails++; $display("FAIL midrst_valid: got %b want 0", o_valid); end
    tick();
    rst = 1'b0;
    repeat (3) begin
      tick();
      tests++; if (o_valid !== 1'b0) begin fails++; $display("FAIL midrst_leak: got %b want 0", o_valid); end
    end
  endtask

  task automatic test_width4();
    logic [3:0] am[5] = '{4'hF, 4'h1, 4'h8, 4'h8, 4'hF};
    logic [3:0] bm[5] = '{4'hF, 4'hF, 4'h8, 4'hF, 4'h1};
    logic [9:0] pe[5] = '{10'h0E1, 10'h00F, 10'h040, 10'h078, 10'h00F};
    for (int i = 0; i < 5; i++) begin
      w4_i_valid = 1'b1; w4_a_mant = am[i]; w4_b_mant = bm[i];
      tick();
      w4_i_valid = 1'b0;
      tick();
      tests++;
      if (w4_o_valid !== 1'b1 || w4_o_mant !== pe[i]) begin
        fails++; $display("FAIL w4_prod%0d: valid %b mant %h want 1 %h", i, w4_o_valid, w4_o_mant, pe[i]);
      end
    end
  endtask

  task automatic test_width12();
    logic [11:0] am[5] = '{12'hFFF, 12'h001, 12'h800, 12'h800, 12'hAAA};
    logic [11:0] bm[5] = '{12'hFFF, 12'hFFF, 12'h800, 12'hFFF, 12'h555};
    logic [25:0] pe[5] = '{26'h0FFE001, 26'h0000FFF, 26'h0400000, 26'h07FF800, 26'h038DC72};
    for (int i = 0; i < 5; i++) begin
      w12_i_valid = 1'b1; w12_a_mant = am[i]; w12_b_mant = bm[i];
      tick();
      w12_i_valid = 1'b0;
      tick();
      tests++;
      if (w12_o_valid !== 1'b1 || w12_o_mant !== pe[i]) begin
        fails++; $display("FAIL w12_prod%0d: valid %b mant %h want 1 %h", i, w12_o_valid, w12_o_mant, pe[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_zero();
    test_backpressure();
    test_back_to_back();
    test_reset_midop();
    test_width4();
    test_width12();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
